// File: rtl/ica_pkg.sv
// Shared widths, FSM state encoding and the result record for the ICA PE scheduler.
package ica_pkg;

  localparam int DW    = 16;  // operand width: weights, sample elements, PE a/b/c/x/y/z
  localparam int UW    = 32;  // PE result width
  localparam int NROWS = 3;   // rows of the unmixing matrix W

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [UW-1:0] data;
    logic [1:0]    row;
  } result_t;

endpackage

// File: rtl/ica_res_fifo.sv
// First-word-fall-through result FIFO. The head is presented combinationally
// and reads as zero whenever the FIFO is empty.
module ica_res_fifo
  import ica_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  result_t       push_data,
  input  logic          pop,
  output result_t       head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy flags and the fall-through head.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? '0 : mem[rd_ptr];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ica_pe_sched.sv
// Sequences an external 3-tap MAC PE through the 3x3 unmixing matrix W for
// each sample vector, collecting the three row results in a small FIFO.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high; the source keeps valid and data stable until then.
// s_ready and the PE issue decision depend only on registered state, never on
// m_ready, so downstream backpressure reaches upstream one cycle late at most.
module ica_pe_sched
  import ica_pkg::*;
#(
  parameter int OUT_DEPTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_we,
  input  logic [3:0]    w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x,
  input  logic [DW-1:0] s_y,
  input  logic [DW-1:0] s_z,
  output logic [DW-1:0] pe_a,
  output logic [DW-1:0] pe_b,
  output logic [DW-1:0] pe_c,
  output logic [DW-1:0] pe_x,
  output logic [DW-1:0] pe_y,
  output logic [DW-1:0] pe_z,
  input  logic [UW-1:0] pe_u,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [UW-1:0] m_data,
  output logic [1:0]    m_row,
  output logic          m_last,
  output logic          busy,
  output state_e        dbg_state
);

  localparam int            CW      = $clog2(OUT_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(OUT_DEPTH);
  localparam logic [1:0]    LAST_ROW = 2'(NROWS - 1);

  state_e         state;
  logic [DW-1:0]  w_mem [NROWS*NROWS];
  logic [DW-1:0]  sx, sy, sz;
  logic [1:0]     row;
  logic [1:0]     p_row;
  logic           p_vld;
  logic           issue;
  logic [3:0]     base;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  result_t        head;
  result_t        push_data;

  // Issue only when the FIFO can absorb this row plus the one already in the PE.
  always_comb begin
    issue = (state == RUN) &&
            (({1'b0, fifo_count} + {{CW{1'b0}}, p_vld}) < DEPTH_V);
    base  = {row, 2'b00} - {2'b00, row};  // row*3
    pe_a  = issue ? w_mem[base]        : '0;
    pe_b  = issue ? w_mem[base + 4'd1] : '0;
    pe_c  = issue ? w_mem[base + 4'd2] : '0;
    pe_x  = issue ? sx : '0;
    pe_y  = issue ? sy : '0;
    pe_z  = issue ? sz : '0;
  end

  // Status and handshake outputs.
  always_comb begin
    s_ready   = (state == IDLE) || (issue && (row == LAST_ROW));
    w_ready   = (state == IDLE) && !p_vld;
    busy      = (state == RUN) || p_vld || !fifo_empty;
    m_valid   = !fifo_empty;
    m_data    = head.data;
    m_row     = head.row;
    m_last    = !fifo_empty && (head.row == LAST_ROW);
    push_data = '{data: pe_u, row: p_row};
    dbg_state = state;
  end

  // Weight store, sample latch, row sequencing and the PE-in-flight marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sx    <= '0;
      sy    <= '0;
      sz    <= '0;
      row   <= '0;
      p_row <= '0;
      p_vld <= 1'b0;
      for (int i = 0; i < NROWS*NROWS; i++) w_mem[i] <= '0;
    end else begin
      if (w_we && w_ready && (w_addr < 4'd9)) w_mem[w_addr] <= w_data;
      p_vld <= issue;
      if (issue) p_row <= row;
      case (state)
        IDLE: begin
          if (s_valid) begin
            sx    <= s_x;
            sy    <= s_y;
            sz    <= s_z;
            row   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (row != LAST_ROW) begin
              row <= row + 1'b1;
            end else if (s_valid) begin
              sx  <= s_x;
              sy  <= s_y;
              sz  <= s_z;
              row <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ica_res_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (p_vld),
    .push_data (push_data),
    .pop       (m_valid && m_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ica_pe_sched.sv
// Directed bench for ica_pe_sched with a behavioural 3-tap MAC PE.
module tb_ica_pe_sched;
  import ica_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          w_we;
  logic [3:0]    w_addr;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_x, s_y, s_z;
  logic [DW-1:0] pe_a, pe_b, pe_c, pe_x, pe_y, pe_z;
  logic [UW-1:0] pe_u;
  logic          m_valid;
  logic          m_ready;
  logic [UW-1:0] m_data;
  logic [1:0]    m_row;
  logic          m_last;
  logic          busy;
  state_e        dbg_state;

  ica_pe_sched #(.OUT_DEPTH(3)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_x(pe_x), .pe_y(pe_y), .pe_z(pe_z),
    .pe_u(pe_u),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .busy(busy), .dbg_state(dbg_state)
  );

  // External PE: registered u = a*x + b*y + c*z, wrapping at 32 bits.
  always @(posedge clk) begin
    if (reset) pe_u <= '0;
    else pe_u <= 32'($signed(pe_a)) * 32'($signed(pe_x))
               + 32'($signed(pe_b)) * 32'($signed(pe_y))
               + 32'($signed(pe_c)) * 32'($signed(pe_z));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];   // {data, row, last}
  int          pop_cyc_q[$];

  task automatic exp3(input int a, input int b, input int c);
    exp_q.push_back({32'(a), 2'd0, 1'b0});
    exp_q.push_back({32'(b), 2'd1, 1'b0});
    exp_q.push_back({32'(c), 2'd2, 1'b1});
  endtask

  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got data 0x%0h row %0d, expected no output", m_data, m_row);
      end else begin
        check("result", {29'd0, m_data, m_row, m_last}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic write_w(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = 4'(addr);
    w_data = 16'(data);
    @(posedge clk); #1;
    w_we   = 1'b0;
  endtask

  // Presents a sample and holds it until accepted; s_valid stays high on return.
  task automatic send(input int x, input int y, input int z, output int acc);
    logic ok;
    int   n;
    s_valid = 1'b1;
    s_x = 16'(x);
    s_y = 16'(y);
    s_z = 16'(z);
    n   = 0;
    acc = -1;
    do begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    if (ok) acc = cyc;
    else check("send_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int x, y, z;
    int e0, e1, e2;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, prev_acc, seen;

    // W = diag(1, 2, -3): row i result = W[i][i] * element i.
    tbl[0] = '{1, 1, 1, 1, 2, -3};
    tbl[1] = '{2, 2, 2, 2, 4, -6};
    tbl[2] = '{3, 3, 3, 3, 6, -9};
    tbl[3] = '{-4, 0, 100, -4, 0, -300};
    tbl[4] = '{32767, -1, 5, 32767, -2, -15};

    reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    s_valid = 1'b0; s_x = '0; s_y = '0; s_z = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data",  64'(m_data),  64'(0));
    check("rst_m_row",   64'(m_row),   64'(0));
    check("rst_m_last",  64'(m_last),  64'(0));
    check("rst_busy",    64'(busy),    64'(0));
    check("rst_w_ready", 64'(w_ready), 64'(1));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_pe_ops",  {16'(pe_a), 16'(pe_b), 16'(pe_c), 16'(pe_x | pe_y | pe_z)}, 64'(0));
    check("rst_state",   64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;

    write_w(0, 1); write_w(1, 0); write_w(2, 0);
    write_w(3, 0); write_w(4, 2); write_w(5, 0);
    write_w(6, 0); write_w(7, 0); write_w(8, -3);

    // Single sample: latency 2 cycles, rows on consecutive cycles.
    exp3(5, 14, -33);
    send(5, 7, 11, acc);
    s_valid = 1'b0;
    @(negedge clk); check("lat_cyc0", 64'(m_valid), 64'(0));
    @(negedge clk); check("lat_cyc1", 64'(m_valid), 64'(0));
    @(negedge clk); check("lat_cyc2", {62'(m_valid), m_row}, {62'(1), 2'd0});
    @(negedge clk); check("row1_next", {62'(m_valid), m_row}, {62'(1), 2'd1});
    @(negedge clk); check("row2_next", {61'(m_valid), m_row, m_last}, {61'(1), 2'd2, 1'b1});
    @(posedge clk); #1;
    wait_drain();

    // Table vectors streamed back-to-back with s_valid held.
    pop_cyc_q.delete();
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      exp3(tbl[i].e0, tbl[i].e1, tbl[i].e2);
      send(tbl[i].x, tbl[i].y, tbl[i].z, acc);
      if (i > 0) check("s_ready_period", 64'(acc - prev_acc), 64'(3));
      prev_acc = acc;
    end
    s_valid = 1'b0;
    wait_drain();
    if (pop_cyc_q.size() == 15) check("stream_no_bubble", 64'(pop_cyc_q[14] - pop_cyc_q[0]), 64'(14));
    else check("stream_count", 64'(pop_cyc_q.size()), 64'(15));

    // Backpressure: FIFO fills to 3, the next sample stalls in RUN.
    m_ready = 1'b0;
    exp3(1, 2, -3);
    exp3(2, 4, -6);
    send(1, 1, 1, acc);
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_head", {29'd0, m_data, m_row, m_valid}, {29'd0, 32'd1, 2'd0, 1'b1});
    @(posedge clk); #1;
    send(2, 2, 2, acc);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_stall_state", 64'(dbg_state), 64'(RUN));
    check("bp_stall_s_ready", 64'(s_ready), 64'(0));
    check("bp_stall_w_ready", 64'(w_ready), 64'(0));
    check("bp_stall_pe_a", {48'd0, pe_a}, 64'(0));
    check("bp_stall_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();

    // Weight write during RUN is dropped; in IDLE it lands.
    exp3(5, 14, -33);
    send(5, 7, 11, acc);
    s_valid = 1'b0;
    w_we = 1'b1; w_addr = 4'd0; w_data = 16'd9;
    @(negedge clk); check("wr_blocked_run", 64'(w_ready), 64'(0));
    @(posedge clk); #1;
    w_we = 1'b0;
    wait_drain();
    @(negedge clk); check("wr_ready_idle", 64'(w_ready), 64'(1));
    @(posedge clk); #1;
    write_w(0, 9);
    exp3(45, 14, -33);
    send(5, 7, 11, acc);
    s_valid = 1'b0;
    wait_drain();

    // Reset after row 1 issue discards everything, including W.
    m_ready = 1'b0;
    send(5, 7, 11, acc);
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    check("no_out_after_reset", 64'(seen), 64'(0));
    @(posedge clk); #1;
    exp3(0, 0, 0);
    send(5, 7, 11, acc);
    s_valid = 1'b0;
    wait_drain();

    // Overflow wraps: 2 * (-32768 * -32768) = 2^31.
    write_w(0, -32768);
    write_w(1, -32768);
    exp3(32'h8000_0000, 0, 0);
    send(-32768, -32768, 0, acc);
    s_valid = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ica_pe_sched.md
Name: ica_pe_sched

Overview:
- Sequences one `pe` 3-tap MAC (u = a*x + b*y + c*z, signed 16-bit in, 32-bit out, 1-cycle registered) through a 3x3 unmixing matrix W for each 3-element sample vector.
- Produces three 32-bit outputs per sample, ordered row 0, 1, 2.
- Sits between the sample source and the ICA update logic.
- The PE is instantiated outside this block. The controller drives the PE operand ports and consumes its `u`.

Parameters:
- DW, 16, operand width (W entries, sample elements, PE a/b/c/x/y/z).
- UW, 32, PE result width.
- OUT_DEPTH, 3, result FIFO depth. Minimum 2. A value of 3 or more gives 1 row/cycle with m_ready held high.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- w_we  in  1  weight write strobe.
- w_addr  in  4  weight index, row*3+col, 0..8. Values 9..15 are ignored.
- w_data  in  DW  signed weight.
- w_ready  out  1  weight writes are accepted (state IDLE and no rows in flight).
- s_valid  in  1  sample vector valid.
- s_ready  out  1  sample accepted this cycle when high with s_valid.
- s_x, s_y, s_z  in  DW each  signed sample elements.
- pe_a, pe_b, pe_c  out  DW each  W[row][0..2] to the PE.
- pe_x, pe_y, pe_z  out  DW each  latched sample to the PE.
- pe_u  in  UW  PE result, valid one cycle after issue.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accepts result.
- m_data  out  UW  signed result.
- m_row  out  2  row index, 0..2.
- m_last  out  1  high when m_row==2.
- busy  out  1  state RUN, or rows in flight, or FIFO non-empty.

Behaviour:
- Reset:
  - state=IDLE, W all 0, sample regs 0, row=0, p_vld=0, FIFO empty.
  - m_valid=0, m_data=0, m_row=0, m_last=0, busy=0, w_ready=1, s_ready=1.
  - All pe_* operands are 0.
- Reset mid-operation discards in-flight rows and FIFO contents. No output appears afterwards. The PE shares the same reset.
- Weight write: if w_we && w_ready && w_addr<9, then W[w_addr] <= w_data at the edge. A write with w_ready=0 is dropped, with no side effect.
- States:
  - IDLE: s_ready=1. On s_valid, latch s_x/y/z, set row=0, go to RUN.
  - RUN: each cycle, issue = (fifo_count + p_vld) < OUT_DEPTH.
    - When issue is high: pe_a/b/c = W[row], pe_x/y/z = sample regs, p_vld<=1, p_row<=row.
    - When issue is low: p_vld<=0 and pe_* are driven to 0, so the PE output is deterministic.
    - Issue with row<2: row<=row+1.
    - Issue with row==2: if s_valid, latch the new sample, row<=0, stay in RUN. Otherwise go to IDLE. s_ready = (row==2 && issue).
- In IDLE, pe_* operands are 0 and p_vld<=0.
- Capture: when p_vld is high, push {pe_u, p_row} into the FIFO on the next edge. Room for this entry is guaranteed by the issue rule.
- FIFO:
  - First-word-fall-through; m_valid = !empty. The head drives m_data, m_row and m_last.
  - Pop on m_valid && m_ready. Push and pop in the same cycle leave the count unchanged.
- Latency: row 0 result is visible on m_* 2 cycles after sample acceptance. Rows 1 and 2 follow on consecutive cycles if m_ready stays high.
- Throughput is 3 cycles per sample when back-to-back: no bubble between samples when s_valid is held.
- There are no combinational paths from m_ready to s_ready or to issue.
- Arithmetic: pe_u is passed through unmodified. Overflow wraps per PE, for example all operands at -32768.
- Weight writes are blocked (w_ready=0) while RUN or p_vld is active, so every row of a sample uses a consistent W. FIFO contents do not block writes.
- s_valid with s_ready=0 is held by the source. AXI-style rules apply: no dropping, data stable while valid.

Decomposition:
- Package ica_pkg: DW, UW, NROWS=3, the state enum {IDLE, RUN}, and the result struct {data, row}.
- One sub-module, ica_res_fifo: a parameterised first-word-fall-through FIFO with depth OUT_DEPTH, push/pop/count, and synchronous active-high reset.

Test Plan:
- Load W = [[1,0,0],[0,2,0],[0,0,-3]], send sample (5,7,11) with m_ready=1 -> m_data 5, 14, -33 with m_row 0, 1, 2 on three consecutive cycles starting 2 cycles after acceptance, and m_last only on the third.
- Same W, hold s_valid over samples (1,1,1), (2,2,2), (3,3,3) -> 9 results on consecutive cycles (1,2,-3, 2,4,-6, 3,6,-9); s_ready pulses once every 3 cycles.
- Hold m_ready=0 and send one sample -> issue stalls with 3 entries in the FIFO. Release m_ready -> results 1,2,-3 in order, none lost or duplicated.
- Assert w_we with addr 0, data 9 during RUN -> write dropped (w_ready=0) and the sample uses W[0][0]=1. The same write in IDLE -> the next sample's row 0 uses 9.
- Assert reset for 1 cycle after row 1 is issued -> m_valid=0 from the next cycle, W all 0, no further results; a following sample yields 0, 0, 0.
- W row 0 = (-32768, -32768, 0), sample (-32768, -32768, 0) -> m_data = 0x80000000 (wrapped), m_row=0.
